// File: rtl/cfg_io_block.sv
// Configurable I/O block: a serial shadow config chain committed into an active config
// that routes pad inputs onto routing tracks and routing tracks out to pads.
module cfg_io_block #(
  parameter  int WS     = 6,
  parameter  int WD     = 3,
  parameter  int WG     = 3,
  parameter  int EXTIN  = 3,
  parameter  int EXTOUT = 3,
  localparam int NT     = WS + WD + WG,
  localparam int SW     = $clog2(NT),
  localparam int CW     = SW + 2,
  localparam int CFGW   = (EXTIN + EXTOUT) * CW
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_en,
  input  logic              cfg_in,
  input  logic              cfg_commit,
  output logic              cfg_out,
  output logic              cfg_ready,
  output logic              cfg_err,
  input  logic [NT-1:0]     track_in,
  output logic [NT-1:0]     track_out,
  output logic [NT-1:0]     track_oe,
  input  logic [EXTIN-1:0]  external_input,
  output logic [EXTOUT-1:0] external_output
);

  localparam int NCH  = EXTIN + EXTOUT;
  localparam int CNTW = $clog2(CFGW + 1);
  localparam logic [SW:0]     NT_C   = NT[SW:0];
  localparam logic [CNTW-1:0] CFGW_C = CFGW[CNTW-1:0];

  logic [CFGW-1:0]   r_shadow;
  logic [CFGW-1:0]   r_active;
  logic [CNTW-1:0]   r_count;
  logic              r_err;
  logic [EXTIN-1:0]  r_ein_q;
  logic [EXTOUT-1:0] r_tin_q;

  logic [SW-1:0]     w_sel   [NCH];
  logic              w_reg   [NCH];
  logic              w_selok [NCH];
  logic              w_vld   [NCH];
  logic [EXTOUT-1:0] w_tin_sel;
  logic [NT-1:0]     w_oe;
  logic [NT-1:0]     w_out;
  logic              w_accept;

  // Field decode of the active config only; the shadow never reaches routing.
  for (genvar k = 0; k < NCH; k++) begin : g_fld
    assign w_sel[k]   = r_active[k*CW +: SW];
    assign w_reg[k]   = r_active[k*CW + SW];
    assign w_selok[k] = ({1'b0, w_sel[k]} < NT_C);
    assign w_vld[k]   = r_active[k*CW + SW + 1] & w_selok[k];
  end

  for (genvar j = 0; j < EXTOUT; j++) begin : g_out
    assign w_tin_sel[j]       = w_selok[EXTIN+j] ? track_in[w_sel[EXTIN+j]] : 1'b0;
    assign external_output[j] = w_vld[EXTIN+j]
                              ? (w_reg[EXTIN+j] ? r_tin_q[j] : w_tin_sel[j])
                              : 1'b0;
  end

  // Ascending scan with a claimed-track test gives the lowest channel priority.
  always_comb begin
    w_oe  = '0;
    w_out = '0;
    for (int unsigned i = 0; i < EXTIN; i++) begin
      if (w_vld[i] && !w_oe[w_sel[i]]) begin
        w_oe[w_sel[i]]  = 1'b1;
        w_out[w_sel[i]] = w_reg[i] ? r_ein_q[i] : external_input[i];
      end
    end
  end

  assign track_oe  = w_oe;
  assign track_out = w_out;
  assign cfg_out   = r_shadow[0];
  assign cfg_ready = (r_count == CFGW_C);
  assign cfg_err   = r_err;
  assign w_accept  = cfg_commit & ~cfg_en & cfg_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shadow <= '0;
      r_active <= '0;
      r_count  <= '0;
      r_err    <= 1'b0;
      r_ein_q  <= '0;
      r_tin_q  <= '0;
    end else begin
      r_ein_q <= external_input;
      r_tin_q <= w_tin_sel;
      if (cfg_en) begin
        r_shadow <= {cfg_in, r_shadow[CFGW-1:1]};
        if (r_count != CFGW_C) r_count <= r_count + 1'b1;
      end
      if (w_accept) begin
        r_active <= r_shadow;
        r_count  <= '0;
        r_err    <= 1'b0;
      end else if (cfg_commit) begin
        r_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_cfg_io_block.sv
// Scoreboard bench for cfg_io_block at default parameters (NT=12, CW=6, CFGW=36).
module tb_cfg_io_block;

  localparam int NT   = 12;
  localparam int CFGW = 36;

  logic          clk = 1'b0;
  logic          rst_n, cfg_en, cfg_in, cfg_commit;
  logic          cfg_out, cfg_ready, cfg_err;
  logic [NT-1:0] track_in, track_out, track_oe;
  logic [2:0]    external_input, external_output;

  cfg_io_block #(.WS(6), .WD(3), .WG(3), .EXTIN(3), .EXTOUT(3)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_en(cfg_en), .cfg_in(cfg_in),
    .cfg_commit(cfg_commit), .cfg_out(cfg_out), .cfg_ready(cfg_ready),
    .cfg_err(cfg_err), .track_in(track_in), .track_out(track_out),
    .track_oe(track_oe), .external_input(external_input),
    .external_output(external_output)
  );

  always #5 clk = ~clk;

  typedef enum logic [2:0] {S_OE, S_OUT, S_EXT, S_ERR, S_RDY, S_SO} sig_e;
  typedef struct {
    sig_e        sig;
    string       tag;
    logic [63:0] exp;
  } exp_t;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", tag, obs, exp);
  endtask

  function automatic logic [63:0] obs_of(input sig_e s);
    case (s)
      S_OE:    return 64'(track_oe);
      S_OUT:   return 64'(track_out);
      S_EXT:   return 64'(external_output);
      S_ERR:   return 64'(cfg_err);
      S_RDY:   return 64'(cfg_ready);
      default: return 64'(cfg_out);
    endcase
  endfunction

  task automatic expect_val(input sig_e s, input string tag, input logic [63:0] v);
    exp_t e;
    e.sig = s; e.tag = tag; e.exp = v;
    sb.push_back(e);
  endtask

  task automatic drain();
    #1;
    while (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      check(e.tag, obs_of(e.sig), e.exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [35:0] put(input logic [35:0] w, input int k,
                                      input logic en, input logic rg, input logic [3:0] sel);
    w[k*6 +: 6] = {en, rg, sel};
    return w;
  endfunction

  task automatic shift_bits(input logic [35:0] w, input int from, input int to);
    for (int i = from; i < to; i++) begin
      cfg_en = 1'b1;
      cfg_in = w[i];
      step();
    end
    cfg_en = 1'b0;
    cfg_in = 1'b0;
  endtask

  task automatic commit();
    cfg_commit = 1'b1;
    step();
    cfg_commit = 1'b0;
  endtask

  logic [35:0] c0, c3, d, p, q, r, f;

  initial begin
    rst_n = 1'b0; cfg_en = 1'b0; cfg_in = 1'b0; cfg_commit = 1'b0;
    track_in = '0; external_input = '0;
    c0 = put('0, 0, 1'b1, 1'b0, 4'd7);
    c3 = put(put(put('0, 3, 1'b1, 1'b1, 4'd2), 4, 1'b1, 1'b0, 4'd5), 5, 1'b1, 1'b0, 4'd13);
    d  = put(put('0, 0, 1'b1, 1'b0, 4'd4), 2, 1'b1, 1'b0, 4'd4);
    p  = put(put('0, 1, 1'b1, 1'b0, 4'd11), 4, 1'b1, 1'b0, 4'd0);
    q  = 36'(({$urandom(), $urandom()}));
    r  = 36'(({$urandom(), $urandom()}));
    f  = put(put(put(put('0, 0, 1'b1, 1'b1, 4'd3), 1, 1'b1, 1'b0, 4'd14),
                 3, 1'b0, 1'b0, 4'd2), 5, 1'b1, 1'b0, 4'd12);

    // Reset state
    step(); step();
    expect_val(S_OE, "rst_oe", 0);   expect_val(S_OUT, "rst_out", 0);
    expect_val(S_EXT, "rst_ext", 0); expect_val(S_SO, "rst_cfgout", 0);
    expect_val(S_RDY, "rst_rdy", 0); expect_val(S_ERR, "rst_err", 0);
    drain();
    rst_n = 1'b1;
    step();

    // Channel 0 combinational input onto track 7
    shift_bits(c0, 0, CFGW);
    expect_val(S_RDY, "c0_rdy", 1); expect_val(S_OE, "c0_shadow_no_oe", 0);
    drain();
    commit();
    external_input = 3'b001;
    expect_val(S_OE, "c0_oe", 12'h080); expect_val(S_OUT, "c0_out", 12'h080);
    expect_val(S_RDY, "c0_rdy_clr", 0); expect_val(S_ERR, "c0_err", 0);
    drain();
    external_input = 3'b000;
    expect_val(S_OE, "c0_oe_lo", 12'h080); expect_val(S_OUT, "c0_out_lo", 0);
    drain();

    // Registered output path latency, combinational output, out-of-range select
    shift_bits(c3, 0, CFGW);
    commit();
    track_in = 12'h020;
    expect_val(S_EXT, "c3_comb", 3'b010); expect_val(S_OE, "c3_oe", 0);
    drain();
    step();
    track_in = 12'h024;
    expect_val(S_EXT, "c3_reg_before", 3'b010);
    drain();
    step();
    expect_val(S_EXT, "c3_reg_after", 3'b011);
    drain();

    // Early commit rejected, completed load accepted
    shift_bits(d, 0, CFGW - 1);
    expect_val(S_RDY, "d35_rdy", 0);
    drain();
    commit();
    expect_val(S_ERR, "d35_err", 1); expect_val(S_EXT, "d35_ext_hold", 3'b011);
    expect_val(S_OE, "d35_oe_hold", 0);
    drain();
    shift_bits(d, CFGW - 1, CFGW);
    expect_val(S_RDY, "d36_rdy", 1); expect_val(S_ERR, "d36_err_sticky", 1);
    drain();
    commit();
    expect_val(S_ERR, "d_err_clr", 0); expect_val(S_EXT, "d_ext", 0);
    drain();

    // Two channels on track 4: channel 0 wins
    external_input = 3'b100;
    expect_val(S_OE, "prio_oe", 12'h010); expect_val(S_OUT, "prio_100", 0);
    drain();
    external_input = 3'b001;
    expect_val(S_OUT, "prio_001", 12'h010);
    drain();
    external_input = 3'b101;
    expect_val(S_OUT, "prio_101", 12'h010);
    drain();

    // Shadow load does not disturb routing
    external_input = 3'b001;
    shift_bits(p, 0, CFGW / 2);
    expect_val(S_OE, "pmid_oe", 12'h010); expect_val(S_OUT, "pmid_out", 12'h010);
    drain();
    shift_bits(p, CFGW / 2, CFGW);
    expect_val(S_OE, "pend_oe", 12'h010); expect_val(S_OUT, "pend_out", 12'h010);
    drain();
    commit();
    external_input = 3'b010;
    track_in = 12'h001;
    expect_val(S_ERR, "p_err", 0); expect_val(S_OE, "p_oe", 12'h800);
    expect_val(S_OUT, "p_out", 12'h800); expect_val(S_EXT, "p_ext", 3'b010);
    drain();

    // Chain output replays P; a commit during a shift is rejected but the shift proceeds
    for (int k = 0; k < CFGW; k++) begin
      expect_val(S_SO, $sformatf("so_%0d", k), 64'(p[k]));
      drain();
      cfg_en = 1'b1;
      cfg_in = q[k];
      cfg_commit = (k == 10);
      step();
      cfg_commit = 1'b0;
    end
    cfg_en = 1'b0;
    expect_val(S_ERR, "shift_commit_err", 1); expect_val(S_RDY, "q_rdy", 1);
    expect_val(S_OE, "q_oe_hold", 12'h800);
    drain();

    // Reset mid-shift with active routing
    commit();
    shift_bits(r, 0, 20);
    cfg_en = 1'b1;
    cfg_in = r[20];
    #1;
    rst_n = 1'b0;
    expect_val(S_OE, "arst_oe", 0);   expect_val(S_OUT, "arst_out", 0);
    expect_val(S_EXT, "arst_ext", 0); expect_val(S_SO, "arst_cfgout", 0);
    expect_val(S_RDY, "arst_rdy", 0); expect_val(S_ERR, "arst_err", 0);
    drain();
    cfg_en = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    expect_val(S_RDY, "post_rst_rdy", 0);
    drain();
    commit();
    expect_val(S_ERR, "post_rst_commit_err", 1); expect_val(S_OE, "post_rst_oe", 0);
    drain();

    // Fresh load: registered input path, disabled and out-of-range channels
    external_input = 3'b010;
    track_in = 12'h004;
    shift_bits(f, 0, CFGW);
    commit();
    expect_val(S_ERR, "f_err", 0); expect_val(S_EXT, "f_ext", 0);
    expect_val(S_OE, "f_oe", 12'h008); expect_val(S_OUT, "f_out_prev", 0);
    drain();
    external_input = 3'b011;
    expect_val(S_OUT, "f_out_still_prev", 0);
    drain();
    step();
    expect_val(S_OUT, "f_out_reg", 12'h008); expect_val(S_OE, "f_oe2", 12'h008);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
